// File: rtl/eth_40gb_pkg.sv
// Shared types and parameter defaults for the 40G Ethernet link bring-up controller.
package eth_40gb_pkg;

  typedef enum logic [2:0] {
    StResetPhy = 3'd0,
    StWaitTx   = 3'd1,
    StWaitRx   = 3'd2,
    StWaitLock = 3'd3,
    StStable   = 3'd4,
    StLinkUp   = 3'd5,
    StFault    = 3'd6
  } link_state_t;

  localparam int unsigned DefaultResetHold    = 32;
  localparam int unsigned DefaultLockTimeout  = 1_000_000;
  localparam int unsigned DefaultStableCycles = 4096;
  localparam int unsigned DefaultMaxRetries   = 8;

endpackage

// File: rtl/eth_40gb_link_ctrl.sv
// Link bring-up sequencer: PHY reset, TX/RX ready, block/alignment lock, stability
// qualification, link-up supervision with bounded retries before declaring a fault.
module eth_40gb_link_ctrl
  import eth_40gb_pkg::*;
#(
  parameter int unsigned RESET_HOLD    = DefaultResetHold,
  parameter int unsigned LOCK_TIMEOUT  = DefaultLockTimeout,
  parameter int unsigned STABLE_CYCLES = DefaultStableCycles,
  parameter int unsigned MAX_RETRIES   = DefaultMaxRetries
) (
  input  logic        core_clk,
  input  logic        core_reset,
  input  logic        restart,
  input  logic [3:0]  tx_ready,
  input  logic [3:0]  rx_ready,
  input  logic [3:0]  rx_blk_lock,
  input  logic        align_locked,
  input  logic        hi_ber,
  input  logic        loopback_en,
  output logic        phy_reset,
  output logic        pcs_reset,
  output logic        link_up,
  output logic        tx_enable,
  output logic        fault,
  output logic [2:0]  state,
  output logic [3:0]  retry_cnt,
  output logic [15:0] link_drop_cnt
);

  localparam int unsigned HoldW  = $clog2(RESET_HOLD + 1);
  localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned StabW  = $clog2(STABLE_CYCLES + 1);

  link_state_t       st_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [StabW-1:0]  stab_q, stab_d;
  logic [3:0]        retry_q, retry_d, retry_inc;
  logic [15:0]       drop_q, drop_d;
  logic              lb_q;
  logic              tx_all, rx_all, links_ok, good, lb_change, timed_out;
  logic              drop_pulse, timeout_hit, enter;

  assign tx_all    = &tx_ready;
  assign rx_all    = &rx_ready;
  assign links_ok  = tx_all & rx_all;
  assign good      = (&rx_blk_lock) & align_locked & ~hi_ber;
  assign lb_change = loopback_en ^ lb_q;
  assign timed_out = (timer_q == TimerW'(LOCK_TIMEOUT - 1));
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d     = st_q;
    hold_d      = hold_q;
    stab_d      = stab_q;
    retry_d     = retry_q;
    drop_d      = drop_q;
    drop_pulse  = 1'b0;
    timeout_hit = 1'b0;

    if (restart || lb_change) begin
      state_d = StResetPhy;
      retry_d = '0;
    end else begin
      unique case (st_q)
        StResetPhy: begin
          if (hold_q == HoldW'(RESET_HOLD - 1)) state_d = StWaitTx;
          else                                  hold_d  = hold_q + HoldW'(1);
        end
        StWaitTx: begin
          if (tx_all) state_d     = StWaitRx;
          else        timeout_hit = timed_out;
        end
        StWaitRx: begin
          if (!tx_all)     state_d     = StResetPhy;
          else if (rx_all) state_d     = StWaitLock;
          else             timeout_hit = timed_out;
        end
        StWaitLock: begin
          if (!links_ok)  state_d     = StResetPhy;
          else if (good)  state_d     = StStable;
          else            timeout_hit = timed_out;
        end
        StStable: begin
          if (!links_ok)                                   state_d = StResetPhy;
          else if (!good)                                  state_d = StWaitLock;
          else if (stab_q == StabW'(STABLE_CYCLES - 1))    state_d = StLinkUp;
          else begin
            stab_d      = stab_q + StabW'(1);
            timeout_hit = timed_out;
          end
        end
        StLinkUp: begin
          // PHY loss outranks a PCS-level drop and is not counted as one
          if (!links_ok) state_d = StResetPhy;
          else if (!good) begin
            state_d    = StWaitLock;
            drop_pulse = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end
        end
        StFault:  state_d = StFault;
        default:  state_d = StResetPhy;
      endcase

      if (timeout_hit) begin
        retry_d = retry_inc;
        state_d = (retry_inc == 4'(MAX_RETRIES)) ? StFault : StResetPhy;
      end
    end

    // A restart counts as a fresh entry even when already in reset
    enter = restart || lb_change || (state_d != st_q);
    if (enter) begin
      hold_d = '0;
      stab_d = '0;
    end
    if (state_d == StLinkUp && st_q != StLinkUp) retry_d = '0;

    if (enter)           timer_d = '0;
    else if (!timed_out) timer_d = timer_q + TimerW'(1);
    else                 timer_d = timer_q;
  end

  always_ff @(posedge core_clk) begin
    lb_q <= loopback_en;
    if (core_reset) begin
      st_q      <= StResetPhy;
      hold_q    <= '0;
      timer_q   <= '0;
      stab_q    <= '0;
      retry_q   <= '0;
      drop_q    <= '0;
      phy_reset <= 1'b1;
      pcs_reset <= 1'b1;
      link_up   <= 1'b0;
      tx_enable <= 1'b0;
      fault     <= 1'b0;
    end else begin
      st_q      <= state_d;
      hold_q    <= hold_d;
      timer_q   <= timer_d;
      stab_q    <= stab_d;
      retry_q   <= retry_d;
      drop_q    <= drop_d;
      phy_reset <= (state_d == StResetPhy) || (state_d == StFault);
      pcs_reset <= (state_d inside {StResetPhy, StWaitTx, StWaitRx, StFault}) || drop_pulse;
      link_up   <= (state_d == StLinkUp);
      tx_enable <= (state_d == StLinkUp);
      fault     <= (state_d == StFault);
    end
  end

  assign state         = st_q;
  assign retry_cnt     = retry_q;
  assign link_drop_cnt = drop_q;

endmodule

// File: tb/tb_eth_40gb_link_ctrl.sv
// Bench for eth_40gb_link_ctrl: directed bring-up scenarios plus randomized status noise,
// all checked every cycle against a cycles-in-state behavioural model.
module tb_eth_40gb_link_ctrl;
  import eth_40gb_pkg::*;

  localparam int RH = 4;
  localparam int LT = 100;
  localparam int SC = 8;
  localparam int MR = 3;

  logic        core_clk, core_reset, restart, align_locked, hi_ber, loopback_en;
  logic [3:0]  tx_ready, rx_ready, rx_blk_lock;
  logic        phy_reset, pcs_reset, link_up, tx_enable, fault;
  logic [2:0]  state;
  logic [3:0]  retry_cnt;
  logic [15:0] link_drop_cnt;

  eth_40gb_link_ctrl #(
    .RESET_HOLD   (RH),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .core_clk     (core_clk),
    .core_reset   (core_reset),
    .restart      (restart),
    .tx_ready     (tx_ready),
    .rx_ready     (rx_ready),
    .rx_blk_lock  (rx_blk_lock),
    .align_locked (align_locked),
    .hi_ber       (hi_ber),
    .loopback_en  (loopback_en),
    .phy_reset    (phy_reset),
    .pcs_reset    (pcs_reset),
    .link_up      (link_up),
    .tx_enable    (tx_enable),
    .fault        (fault),
    .state        (state),
    .retry_cnt    (retry_cnt),
    .link_drop_cnt(link_drop_cnt)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: current state, edges spent in it, retry and drop counts.
  link_state_t m_st      = StResetPhy;
  int          m_age     = 0;
  int          m_retry   = 0;
  int          m_drops   = 0;
  bit          m_pulse   = 1'b0;
  bit          m_lb_prev = 1'b0;

  task automatic model_step();
    bit txa, rxa, good, lbchg, moved, lost;
    link_state_t nxt;
    txa   = (tx_ready == 4'hF);
    rxa   = (rx_ready == 4'hF);
    good  = (rx_blk_lock == 4'hF) && align_locked && !hi_ber;
    lbchg = (loopback_en != m_lb_prev);
    m_lb_prev = loopback_en;
    m_pulse   = 1'b0;
    if (core_reset) begin
      m_st = StResetPhy; m_age = 0; m_retry = 0; m_drops = 0;
      return;
    end
    nxt   = m_st;
    moved = 1'b0;
    if (restart || lbchg) begin
      nxt = StResetPhy; moved = 1'b1; m_retry = 0;
    end else if (m_st == StResetPhy) begin
      if (m_age + 1 == RH) begin nxt = StWaitTx; moved = 1'b1; end
    end else if (m_st != StFault) begin
      lost = (m_st != StWaitTx) && (!txa || (m_st != StWaitRx && !rxa));
      moved = 1'b1;
      if (lost)                                  nxt = StResetPhy;
      else if (m_st == StWaitTx && txa)          nxt = StWaitRx;
      else if (m_st == StWaitRx && rxa)          nxt = StWaitLock;
      else if (m_st == StWaitLock && good)       nxt = StStable;
      else if (m_st == StStable && !good)        nxt = StWaitLock;
      else if (m_st == StStable && m_age + 1 == SC) begin
        nxt = StLinkUp; m_retry = 0;
      end else if (m_st == StLinkUp && !good) begin
        nxt = StWaitLock; m_pulse = 1'b1;
        m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
      end else if (m_st != StLinkUp && m_age + 1 >= LT) begin
        m_retry++;
        nxt = (m_retry == MR) ? StFault : StResetPhy;
      end else moved = 1'b0;
    end
    if (moved) begin m_st = nxt; m_age = 0; end
    else m_age++;
  endtask

  initial begin
    forever begin
      @(posedge core_clk);
      model_step();
      #1;
      chk("state",         state,         m_st);
      chk("phy_reset",     phy_reset,     m_st == StResetPhy || m_st == StFault);
      chk("pcs_reset",     pcs_reset,     m_st inside {StResetPhy, StWaitTx, StWaitRx, StFault}
                                          || m_pulse);
      chk("link_up",       link_up,       m_st == StLinkUp);
      chk("tx_enable",     tx_enable,     m_st == StLinkUp);
      chk("fault",         fault,         m_st == StFault);
      chk("retry_cnt",     retry_cnt,     m_retry);
      chk("link_drop_cnt", link_drop_cnt, m_drops);
    end
  end

  task automatic set_good();
    tx_ready = 4'hF; rx_ready = 4'hF; rx_blk_lock = 4'hF;
    align_locked = 1'b1; hi_ber = 1'b0;
  endtask

  task automatic wait_state(input link_state_t st, input int bound, input string name,
                            output int k);
    k = 0;
    while (k < bound && state !== st) begin
      @(negedge core_clk);
      k++;
    end
    chk(name, state, st);
  endtask

  initial begin
    int k, ph, lu;
    core_reset = 1'b1; restart = 1'b0; loopback_en = 1'b0;
    set_good();

    // Scenario 1: clean bring-up
    repeat (3) @(negedge core_clk);
    core_reset = 1'b0;
    ph = 0; lu = -1;
    for (int c = 0; c < 40; c++) begin
      if (phy_reset === 1'b1 && c == ph) ph++;
      if (link_up === 1'b1 && lu < 0) lu = c;
      @(negedge core_clk);
    end
    chk("s1_phy_hold", ph, 4);
    chk("s1_linkup_cycle", lu, 15);
    chk("s1_retry", retry_cnt, 0);
    chk("s1_model_state", m_st, StLinkUp);

    // Scenario 2: one lane never locks -> three timeouts then fault
    rx_blk_lock = 4'b0111;
    wait_state(StFault, 600, "s2_reach_fault", k);
    chk("s2_fault_latency", k, 313);
    chk("s2_fault", fault, 1);
    chk("s2_retry", retry_cnt, 3);
    chk("s2_model_retry", m_retry, 3);
    restart = 1'b1;
    @(negedge core_clk);
    restart = 1'b0;
    set_good();
    chk("s2_fault_cleared", fault, 0);
    chk("s2_phy_reasserted", phy_reset, 1);
    chk("s2_retry_cleared", retry_cnt, 0);

    // Scenario 3: one-cycle alignment drop in LINK_UP
    core_reset = 1'b1;
    @(negedge core_clk);
    core_reset = 1'b0;
    wait_state(StLinkUp, 40, "s3_reach_linkup", k);
    align_locked = 1'b0;
    @(negedge core_clk);
    align_locked = 1'b1;
    chk("s3_pcs_pulse", pcs_reset, 1);
    chk("s3_drop_cnt", link_drop_cnt, 1);
    chk("s3_link_down", link_up, 0);
    chk("s3_wait_lock", state, StWaitLock);
    @(negedge core_clk);
    chk("s3_pcs_released", pcs_reset, 0);
    chk("s3_stable", state, StStable);
    wait_state(StLinkUp, 40, "s3_relink", k);
    chk("s3_stable_len", k, 8);

    // Scenario 4: hi_ber glitch after 5 stable cycles restarts the count
    restart = 1'b1;
    @(negedge core_clk);
    restart = 1'b0;
    wait_state(StStable, 40, "s4_reach_stable", k);
    repeat (5) @(negedge core_clk);
    hi_ber = 1'b1;
    @(negedge core_clk);
    hi_ber = 1'b0;
    chk("s4_back_to_lock", state, StWaitLock);
    wait_state(StLinkUp, 40, "s4_relink", k);
    chk("s4_full_count", k, 9);

    // Scenario 5: simultaneous tx lane loss and alignment loss
    tx_ready = 4'b1011; align_locked = 1'b0;
    @(negedge core_clk);
    set_good();
    chk("s5_state", state, StResetPhy);
    chk("s5_drop_unchanged", link_drop_cnt, 1);
    chk("s5_retry_unchanged", retry_cnt, 0);
    wait_state(StLinkUp, 40, "s5_relink", k);

    // Scenario 6: loopback toggle, then core_reset while in FAULT
    loopback_en = 1'b1;
    @(negedge core_clk);
    chk("s6_lb_link_down", link_up, 0);
    chk("s6_lb_phy_reset", phy_reset, 1);
    rx_blk_lock = 4'b0111;
    wait_state(StFault, 600, "s6_reach_fault", k);
    core_reset = 1'b1; restart = 1'b1; loopback_en = 1'b0; hi_ber = 1'b1; tx_ready = 4'h0;
    @(negedge core_clk);
    core_reset = 1'b0; restart = 1'b0;
    set_good();
    chk("s6_rst_state", state, StResetPhy);
    chk("s6_rst_phy", phy_reset, 1);
    chk("s6_rst_pcs", pcs_reset, 1);
    chk("s6_rst_link", link_up, 0);
    chk("s6_rst_txen", tx_enable, 0);
    chk("s6_rst_fault", fault, 0);
    chk("s6_rst_retry", retry_cnt, 0);
    chk("s6_rst_drops", link_drop_cnt, 0);

    // Randomized phase: alternate healthy, dead-lane and noisy episodes
    for (int ep = 0; ep < 8; ep++) begin
      for (int c = 0; c < 500; c++) begin
        @(negedge core_clk);
        core_reset = ($urandom_range(0, 1499) == 0);
        restart    = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 599) == 0) loopback_en = ~loopback_en;
        tx_ready = ($urandom_range(0, 299) == 0) ? 4'($urandom) : 4'hF;
        rx_ready = ($urandom_range(0, 299) == 0) ? 4'($urandom) : 4'hF;
        case (ep % 3)
          0: begin
            rx_blk_lock  = ($urandom_range(0, 99) == 0) ? 4'($urandom) : 4'hF;
            align_locked = ($urandom_range(0, 99) != 0);
            hi_ber       = ($urandom_range(0, 149) == 0);
          end
          1: begin
            rx_blk_lock  = 4'b1101;
            align_locked = 1'b1;
            hi_ber       = 1'b0;
          end
          default: begin
            rx_blk_lock  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            align_locked = ($urandom_range(0, 14) != 0);
            hi_ber       = ($urandom_range(0, 19) == 0);
          end
        endcase
      end
    end
    core_reset = 1'b0; restart = 1'b0;
    set_good();
    repeat (5) @(negedge core_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/eth_40gb_link_ctrl.md
EТH_40GB_LINK_CTRL -- requirements
Module: eth_40gb_link_ctrl

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 32: cycles phy_reset stays asserted per reset attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1_000_000: cycles allowed in any WAIT_* state before a retry.
REQ-003 SHALL have parameter STABLE_CYCLES, default 4096: consecutive good cycles required before link_up.
REQ-004 SHALL have parameter MAX_RETRIES, default 8: failed attempts before FAULT.
REQ-005 SHALL have port core_clk  in  1  the single clock; all ports are synchronous to it.
REQ-006 SHALL have port core_reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port restart  in  1  single-cycle request to restart bring-up.
REQ-008 SHALL have ports tx_ready, rx_ready, rx_blk_lock  in  4 each  per-lane PHY status, already synchronous to core_clk.
REQ-009 SHALL have port align_locked  in  1  PCS lane-alignment lock.
REQ-010 SHALL have port hi_ber  in  1  PCS high bit-error-rate flag.
REQ-011 SHALL have port loopback_en  in  1  serial loopback select.
REQ-012 SHALL have ports phy_reset, pcs_reset  out  1 each  reset requests to the PHY reset controller and PCS.
REQ-013 SHALL have ports link_up, tx_enable, fault  out  1 each  link status and TX gating.
REQ-014 SHALL have ports state  out  3  current state encoding; retry_cnt  out  4; link_drop_cnt  out  16.

Function
REQ-015 SHALL implement states RESET_PHY, WAIT_TX, WAIT_RX, WAIT_LOCK, STABLE, LINK_UP, FAULT.
REQ-016 RESET_PHY SHALL assert phy_reset and pcs_reset for exactly RESET_HOLD cycles, then enter WAIT_TX.
REQ-017 WAIT_TX SHALL advance to WAIT_RX on the first cycle &tx_ready=1.
REQ-018 WAIT_RX SHALL advance to WAIT_LOCK on the first cycle &rx_ready=1; pcs_reset stays asserted through WAIT_RX.
REQ-019 WAIT_LOCK SHALL advance to STABLE when &rx_blk_lock and align_locked and not hi_ber ("good").
REQ-020 STABLE SHALL enter LINK_UP after STABLE_CYCLES consecutive good cycles; any non-good cycle returns to WAIT_LOCK and clears the stable count.
REQ-021 LINK_UP SHALL drive link_up=1 and tx_enable=1; these SHALL be 0 in every other state.
REQ-022 In LINK_UP, loss of good SHALL pulse pcs_reset for 1 cycle, increment link_drop_cnt and enter WAIT_LOCK on the next cycle.
REQ-023 In any state after WAIT_TX, loss of &tx_ready or &rx_ready SHALL enter RESET_PHY without incrementing retry_cnt; this takes priority over the loss of good (REQ-022).
REQ-024 A single timeout counter SHALL clear on every state entry; reaching LOCK_TIMEOUT in WAIT_TX, WAIT_RX, WAIT_LOCK or STABLE SHALL increment retry_cnt and enter RESET_PHY.
REQ-025 When the incremented retry_cnt equals MAX_RETRIES, SHALL enter FAULT instead; FAULT drives fault=1 and phy_reset=1 and is left only by restart or core_reset.
REQ-026 retry_cnt SHALL clear on entry to LINK_UP.
REQ-027 restart, or any change of loopback_en (registered edge detect), SHALL enter RESET_PHY on the next cycle from any state, clearing retry_cnt and fault; this has highest priority after core_reset.
REQ-028 link_drop_cnt SHALL saturate at 0xFFFF and clear only on core_reset.
REQ-029 All outputs SHALL be registered; state changes appear on outputs 1 cycle after the causing input.

Reset
REQ-030 core_reset SHALL force state=RESET_PHY, phy_reset=1, pcs_reset=1, link_up=0, tx_enable=0, fault=0, all counters 0, with the hold count restarted.
REQ-031 core_reset asserted mid-operation, including LINK_UP or FAULT, SHALL take effect on the next edge regardless of other inputs.

Structure
REQ-032 Package eth_40gb_pkg SHALL hold the link_state_t enum (3-bit) and the default values of the four parameters.
REQ-033 Counter widths SHALL derive from $clog2 of their parameters; no sub-module is required, and the timers are inline.

Verification (RESET_HOLD=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=3)
REQ-034 Scenario 1: release reset with all status=1 -> phy_reset high for 4 cycles, link_up=1 at the expected cycle count, retry_cnt=0.
REQ-035 Scenario 2: rx_blk_lock=4'b0111 held -> 3 timeouts, then fault=1, retry_cnt=3; a restart pulse then clears fault and phy_reset reasserts.
REQ-036 Scenario 3: in LINK_UP, drop align_locked for 1 cycle -> pcs_reset pulses 1 cycle, link_drop_cnt=1, link_up returns 8 good cycles after WAIT_LOCK exits.
REQ-037 Scenario 4: in STABLE, hi_ber pulses at count 5 -> return to WAIT_LOCK, then a full 8 good cycles are required.
REQ-038 Scenario 5: tx_ready[2] drops and align_locked drops in the same cycle during LINK_UP -> RESET_PHY, link_drop_cnt unchanged, retry_cnt unchanged.
REQ-039 Scenario 6: toggle loopback_en in LINK_UP -> link_up=0 and phy_reset=1 the next output cycle; assert core_reset during FAULT -> all reset values the next cycle.
